// File: rtl/lfsr_misr_bist_pkg.sv
// Shared types and default constants for the scan-based LFSR/MISR BIST block.
// Holds the controller state encoding and the default pattern/signature polynomials.
package lfsr_misr_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_DONE
  } state_t;

  localparam logic [7:0]  DEF_LFSR_SEED = 8'hBD;
  localparam logic [7:0]  DEF_LFSR_TAPS = 8'h8E;
  localparam logic [15:0] DEF_MISR_POLY = 16'h1021;

endpackage

// File: rtl/lfsr_misr_bist_cut_mult.sv
// Circuit under test: unsigned W x W multiplier with a full 2W-bit product.
// fault_inj models a stuck-at-0 on product bit 0.
module bist_cut_mult #(
  parameter int W = 4
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           fault_inj,
  output logic [2*W-1:0] product
);

  logic [2*W-1:0] raw;

  assign raw     = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign product = {raw[2*W-1:1], raw[0] & ~fault_inj};

endmodule

// File: rtl/lfsr_misr_bist.sv
// Scan BIST controller: an LFSR fills the scan chain, the multiplier result is
// captured back into it, and a MISR compacts everything shifted out.
module lfsr_misr_bist
  import lfsr_misr_bist_pkg::*;
#(
  parameter int                 W         = 4,
  parameter int                 LFSR_W    = 8,
  parameter logic [LFSR_W-1:0]  LFSR_SEED = DEF_LFSR_SEED,
  parameter logic [LFSR_W-1:0]  LFSR_TAPS = DEF_LFSR_TAPS,
  parameter int                 MISR_W    = 16,
  parameter logic [MISR_W-1:0]  MISR_POLY = DEF_MISR_POLY,
  parameter int                 NUM_PAT   = 16,
  parameter logic [MISR_W-1:0]  GOLDEN    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              fault_inj,
  output logic              scan_en,
  output logic              scan_in,
  output logic              scan_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  localparam int L  = 2 * W;
  localparam int SW = $clog2(L + 1);
  localparam int PW = $clog2(NUM_PAT + 1);

  state_t              state_reg, state_next;
  logic [LFSR_W-1:0]   lfsr_reg, lfsr_next;
  logic [MISR_W-1:0]   misr_reg, misr_next;
  logic [L-1:0]        chain_reg;
  logic [SW-1:0]       shift_cnt_reg;
  logic [PW-1:0]       pat_cnt_reg;
  logic [L-1:0]        product;
  logic                shift_last, pat_last, launch;

  bist_cut_mult #(.W(W)) u_cut (
    .a         (chain_reg[W-1:0]),
    .b         (chain_reg[L-1:W]),
    .fault_inj (fault_inj),
    .product   (product)
  );

  assign shift_last = (shift_cnt_reg == SW'(L - 1));
  assign pat_last   = (pat_cnt_reg == PW'(NUM_PAT - 1));

  assign scan_in   = lfsr_reg[LFSR_W-1];
  assign scan_out  = chain_reg[L-1];
  assign signature = misr_reg;

  assign lfsr_next = {lfsr_reg[LFSR_W-2:0], ^(lfsr_reg & LFSR_TAPS)};
  // Serial MISR: shift with polynomial feedback, then fold scan_out into bit 0.
  assign misr_next = ({misr_reg[MISR_W-2:0], 1'b0} ^ (misr_reg[MISR_W-1] ? MISR_POLY : '0))
                   ^ {{(MISR_W-1){1'b0}}, scan_out};

  always_comb begin
    state_next = state_reg;
    scan_en    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    launch     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          launch     = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scan_en = 1'b1;
        busy    = 1'b1;
        if (shift_last) state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        busy       = 1'b1;
        state_next = pat_last ? ST_UNLOAD : ST_SHIFT;
      end
      ST_UNLOAD: begin
        scan_en = 1'b1;
        busy    = 1'b1;
        if (shift_last) state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          launch     = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign pass = done && (misr_reg == GOLDEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      lfsr_reg      <= LFSR_SEED;
      misr_reg      <= '0;
      chain_reg     <= '0;
      shift_cnt_reg <= '0;
      pat_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (launch) begin
        lfsr_reg      <= LFSR_SEED;
        misr_reg      <= '0;
        chain_reg     <= '0;
        shift_cnt_reg <= '0;
        pat_cnt_reg   <= '0;
      end else if (scan_en) begin
        chain_reg     <= {chain_reg[L-2:0], scan_in};
        lfsr_reg      <= lfsr_next;
        misr_reg      <= misr_next;
        shift_cnt_reg <= shift_last ? '0 : shift_cnt_reg + SW'(1);
      end else if (state_reg == ST_CAPTURE) begin
        chain_reg   <= product;
        pat_cnt_reg <= pat_cnt_reg + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_lfsr_misr_bist.sv
// Directed bench for lfsr_misr_bist: default-size runs (clean, faulty, rerun,
// mid-run reset) plus a W=8 / NUM_PAT=4 instance, all against a reference model.
module tb_lfsr_misr_bist;

  // Reference algorithm: NUM_PAT load/capture rounds followed by one unload.
  function automatic logic [15:0] model_sig(input int w, input int np, input bit fi);
    logic [7:0]  lfsr;
    logic [31:0] chain, amask, cmask, a, b;
    logic [15:0] misr;
    logic        so, fb;
    int          l;
    l     = 2 * w;
    lfsr  = 8'hBD;
    chain = 32'd0;
    misr  = 16'd0;
    amask = (32'd1 << w) - 32'd1;
    cmask = (32'd1 << l) - 32'd1;
    for (int p = 0; p <= np; p++) begin
      for (int s = 0; s < l; s++) begin
        so    = chain[l-1];
        fb    = misr[15];
        misr  = {misr[14:0], so} ^ (fb ? 16'h1021 : 16'h0000);
        chain = ((chain << 1) | {31'd0, lfsr[7]}) & cmask;
        lfsr  = {lfsr[6:0], ^(lfsr & 8'h8E)};
      end
      if (p < np) begin
        a     = chain & amask;
        b     = (chain >> w) & amask;
        chain = (a * b) & cmask;
        if (fi) chain[0] = 1'b0;
      end
    end
    return misr;
  endfunction

  localparam logic [15:0] GOLD_A = model_sig(4, 16, 1'b0);
  localparam logic [15:0] GOLD_B = model_sig(8, 4, 1'b0);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, fi_a, se_a, si_a, so_a, busy_a, done_a, pass_a;
  logic [15:0] sig_a;
  logic        rst_b, start_b, fi_b, se_b, si_b, so_b, busy_b, done_b, pass_b;
  logic [15:0] sig_b;

  lfsr_misr_bist #(.GOLDEN(GOLD_A)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .fault_inj(fi_a),
    .scan_en(se_a), .scan_in(si_a), .scan_out(so_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .signature(sig_a)
  );

  lfsr_misr_bist #(.W(8), .NUM_PAT(4), .GOLDEN(GOLD_B)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .fault_inj(fi_b),
    .scan_en(se_b), .scan_in(si_b), .scan_out(so_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .signature(sig_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_scan_en"}, 32'(se_a), 32'd0);
    chk({tag, "_busy"},    32'(busy_a), 32'd0);
    chk({tag, "_done"},    32'(done_a), 32'd0);
    chk({tag, "_pass"},    32'(pass_a), 32'd0);
    chk({tag, "_sig"},     32'(sig_a), 32'd0);
    chk({tag, "_scan_out"},32'(so_a), 32'd0);
    chk({tag, "_scan_in"}, 32'(si_a), 32'd1);
  endtask

  // One full run on dut_a; a stray start is pulsed mid-SHIFT and must be ignored.
  task automatic run_a(input bit fi, output logic [15:0] sig, output logic [7:0] prod,
                       output int len);
    logic [7:0] seed;
    seed    = 8'hBD;
    prod    = 8'h00;
    fi_a    = fi;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    len = 0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("scan_in_%0d", k), 32'(si_a), 32'(seed[7-k]));
      if (k == 0) chk("shift_en", 32'({se_a, busy_a, done_a}), 32'b110);
      start_a = (k == 3);
      tick();
      len++;
    end
    chk("capture_en", 32'(se_a), 32'd0);
    chk("capture_chain", 32'(dut_a.chain_reg), 32'hBD);
    tick();
    len++;
    for (int k = 0; k < 8; k++) begin
      prod[7-k] = so_a;
      tick();
      len++;
    end
    while (!done_a && len < 400) begin
      tick();
      len++;
    end
    sig  = sig_a;
    fi_a = 1'b0;
    $display("run fi=%0d len=%0d prod=%02h sig=%04h pass=%0d", fi, len, prod, sig, pass_a);
  endtask

  logic [15:0] sig1, sig2, sig3;
  logic [7:0]  prod;
  int          len;

  initial begin
    rst_a = 1'b1; start_a = 1'b0; fi_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; fi_b = 1'b0;
    repeat (2) tick();
    chk_reset_a("reset");
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    chk_reset_a("idle");

    // Fault-free run from IDLE
    run_a(1'b0, sig1, prod, len);
    chk("run1_prod", 32'(prod), 32'h8F);
    chk("run1_len", 32'(len), 32'd152);
    chk("run1_sig", 32'(sig1), 32'(GOLD_A));
    chk("run1_pass", 32'({pass_a, busy_a}), 32'b10);
    repeat (5) tick();
    chk("done_hold", 32'({done_a, pass_a, sig_a}), 32'({2'b11, sig1}));

    // Restart from DONE must reproduce the signature
    run_a(1'b0, sig2, prod, len);
    chk("run2_len", 32'(len), 32'd152);
    chk("run2_sig", 32'(sig2), 32'(sig1));

    // Stuck-at-0 on product bit 0
    run_a(1'b1, sig3, prod, len);
    chk("fault_prod", 32'(prod), 32'h8E);
    chk("fault_sig", 32'(sig3), 32'(model_sig(4, 16, 1'b1)));
    chk("fault_differs", 32'(sig3 != GOLD_A), 32'd1);
    chk("fault_pass", 32'({done_a, pass_a}), 32'b10);

    // Reset in the middle of UNLOAD
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    len = 0;
    while (len < 147) begin
      tick();
      len++;
    end
    chk("unload_state", 32'({se_a, busy_a, done_a}), 32'b110);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk_reset_a("midrst");
    $display("run mid-unload reset at cycle %0d", len);

    // Reset wins over a simultaneous start
    rst_a = 1'b1; start_a = 1'b1;
    tick();
    rst_a = 1'b0; start_a = 1'b0;
    chk_reset_a("rst_prio");
    tick();
    chk("rst_prio_idle", 32'({se_a, busy_a}), 32'd0);

    // Wider CUT, fewer patterns: 4*17 + 16 = 84 cycles
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    len = 0;
    while (!done_b && len < 400) begin
      tick();
      len++;
    end
    chk("w8_len", 32'(len), 32'd84);
    chk("w8_sig", 32'(sig_b), 32'(GOLD_B));
    chk("w8_pass", 32'({done_b, pass_b}), 32'b11);
    $display("run W=8 len=%0d sig=%04h pass=%0d", len, sig_b, pass_b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_misr_bist.md
LFSR_MISR_BIST -- requirements
Module: lfsr_misr_bist

Interface
REQ-001 Parameter W, default 4: CUT operand width; scan chain length L = 2*W.
REQ-002 Parameter LFSR_W, default 8: pattern LFSR width.
REQ-003 Parameter LFSR_SEED, default 8'hBD: LFSR load value.
REQ-004 Parameter LFSR_TAPS, default 8'h8E: feedback mask (bits 7,3,2,1).
REQ-005 Parameter MISR_W, default 16: signature register width.
REQ-006 Parameter MISR_POLY, default 16'h1021: MISR feedback mask.
REQ-007 Parameter NUM_PAT, default 16: number of capture cycles per run.
REQ-008 Parameter GOLDEN, default 0: expected final signature.
REQ-009 clk  in  1  sole clock; all state updates on its rising edge.
REQ-010 rst  in  1  reset; synchronous, active-high.
REQ-011 start  in  1  one-cycle run request.
REQ-012 fault_inj  in  1  when 1, forces CUT product bit 0 to 0 (stuck-at-0).
REQ-013 scan_en  out  1  1 = chain shifting, 0 = capture or idle.
REQ-014 scan_in  out  1  LFSR output bit into chain bit 0.
REQ-015 scan_out  out  1  chain MSB.
REQ-016 busy  out  1  run in progress.
REQ-017 done  out  1  run complete; held until next start or rst.
REQ-018 pass  out  1  valid while done: signature == GOLDEN.
REQ-019 signature  out  MISR_W  current MISR contents.

Function
REQ-020 FSM states: IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
REQ-021 IDLE/DONE with start=1: next cycle SHIFT; LFSR <= LFSR_SEED, MISR <= 0, chain <= 0, pattern and shift counters <= 0.
REQ-022 start while busy is ignored.
REQ-023 SHIFT: scan_en=1 for exactly L cycles; then CAPTURE.
REQ-024 CAPTURE: scan_en=0 for 1 cycle; pattern count +1; if count reaches NUM_PAT go to UNLOAD, else SHIFT.
REQ-025 UNLOAD: scan_en=1 for exactly L cycles; then DONE.
REQ-026 Each scan_en=1 cycle: chain <= {chain[L-2:0], scan_in}; LFSR advances; MISR absorbs scan_out.
REQ-027 LFSR advances only when scan_en=1: lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)}; scan_in = lfsr[LFSR_W-1].
REQ-028 MISR update: shifted = {misr[MISR_W-2:0],0} ^ (misr[MISR_W-1] ? MISR_POLY : 0); misr <= shifted with bit 0 XORed with scan_out.
REQ-029 CUT: unsigned W x W multiplier; a = chain[W-1:0], b = chain[L-1:W]; product 2W bits, no truncation.
REQ-030 CAPTURE: chain <= product (bit 0 forced 0 if fault_inj).
REQ-031 Run length from first SHIFT cycle to DONE entry: NUM_PAT*(L+1) + L cycles (152 at defaults).
REQ-032 busy=1 in SHIFT, CAPTURE, UNLOAD; done=1 only in DONE; pass=0 outside DONE.
REQ-033 LFSR_SEED = 0 is illegal (lockup); not supported.

Reset
REQ-034 rst=1 at any edge, including mid-run: state IDLE, LFSR <= LFSR_SEED, MISR <= 0, chain <= 0, counters <= 0.
REQ-035 Outputs after reset: scan_en=0, busy=0, done=0, pass=0, signature=0, scan_out=0, scan_in=LFSR_SEED MSB.
REQ-036 rst has priority over start in the same cycle.

Structure
REQ-037 Shared package holds the FSM state enumeration and default LFSR/MISR constants.
REQ-038 One sub-module, bist_cut_mult: parametrised combinational W x W multiplier with fault_inj.
REQ-039 LFSR, MISR, chain, counters and FSM reside in lfsr_misr_bist.

Verification
REQ-040 Reset then start: scan_in over first 8 SHIFT cycles = 1,0,1,1,1,1,0,1; chain = 8'hBD at CAPTURE.
REQ-041 First CAPTURE, fault_inj=0: a=13, b=11 -> chain = 8'h8F.
REQ-042 Same with fault_inj=1 -> chain = 8'h8E; final signature differs from fault-free run.
REQ-043 Full default run: done rises exactly 152 cycles after first SHIFT cycle; pass=1 iff signature == GOLDEN (GOLDEN set from model).
REQ-044 start pulsed during SHIFT -> no restart, cycle count unchanged; rst mid-UNLOAD -> next cycle IDLE, all outputs at reset values.
REQ-045 start in DONE -> rerun yields identical signature; W=8, NUM_PAT=4 run matches reference model.
